keypress_event_ctrl: RTL

Keypress event controller for the game SoC: samples the raw key level lines, debounces them, and detects press and release edges. When several keys change in the same cycle, a round-robin arbiter serialises the events into an event FIFO. The Nios CPU reads that FIFO over an Avalon-MM slave, and an interrupt line tells it when events are waiting. This block replaces direct polling of the single-bit key input port.

---
 rtl/keypress_pkg.sv | 36 +++
 rtl/keypress_event_fifo.sv | 58 +++++
 rtl/keypress_event_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/keypress_pkg.sv
// Shared constants for the keypress event controller: Avalon register map,
// event word layout and status word layout.
package keypress_pkg;

   localparam logic [1:0] ADDR_STATE  = 2'd0;
   localparam logic [1:0] ADDR_EVENT  = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int EVT_VALID_BIT = 31;
   localparam int EVT_LEVEL_BIT = 8;
   localparam int EVT_INDEX_LSB = 0;
   localparam int EVT_INDEX_MSB = 4;
   // FIFO entries hold only {level, index}; valid is implied by non-empty.
   localparam int EVT_W         = 6;

   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_COUNT_MSB = 6;
   localparam int STAT_EMPTY_BIT = 8;
   localparam int STAT_FULL_BIT  = 9;
   localparam int STAT_LOST_BIT  = 10;
   localparam int STAT_PEND_BIT  = 11;

   localparam int CTRL_IRQ_EN_BIT   = 0;
   localparam int CTRL_CLR_LOST_BIT = 1;

   function automatic logic [31:0] event_word(input logic [EVT_W-1:0] ev);
      logic [31:0] w;
      w = '0;
      w[EVT_VALID_BIT] = 1'b1;
      w[EVT_LEVEL_BIT] = ev[EVT_W-1];
      w[EVT_INDEX_MSB:EVT_INDEX_LSB] = ev[4:0];
      return w;
   endfunction

endpackage

// File: rtl/keypress_event_fifo.sv
// Single-clock event FIFO with occupancy count; a push is accepted while
// full when a pop happens in the same cycle.
module keypress_event_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/keypress_event_ctrl.sv
// Keypress event controller: sync + debounce, edge detect, round-robin event
// FIFO, Avalon-MM slave and irq. KEYPRESS_DEBOUNCE_EN builds per-key counters.
module keypress_event_ctrl
   import keypress_pkg::*;
#(
   parameter int NUM_KEYS        = 8,
   parameter int FIFO_DEPTH      = 16,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic [1:0]          address,
   input  logic                read,
   input  logic                write,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic                irq
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q, stable_q, stable_d;
   logic [NUM_KEYS-1:0] pending_q, pending_d, edge_w;
   logic                lost_q, lost_d, irq_en_q, irq_en_d, irq_q;
   logic [KW-1:0]       rr_ptr_q, rr_ptr_d, grant_idx;
   logic                grant_valid;
   logic [31:0]         readdata_q, readdata_d;
   logic [EVT_W-1:0]    fifo_wdata, fifo_rdata;
   logic                fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0]       fifo_count;
   logic                ctrl_wr;
   logic                unused_wdata;

   assign unused_wdata = ^writedata[31:2];
   assign ctrl_wr      = write && (address == ADDR_CTRL);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= key_in;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
      end
   end

`ifdef KEYPRESS_DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   logic [DBW-1:0] db_cnt_q [NUM_KEYS];
   logic [DBW-1:0] db_cnt_d [NUM_KEYS];

   // A counter only advances while the synchronised level disagrees with stable.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            stable_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (reset) db_cnt_q[i] <= '0;
         else       db_cnt_q[i] <= db_cnt_d[i];
      end
   end
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign stable_d = sync2_q;
`endif

   // Edge is seen in the same cycle stable updates, so no extra pipeline stage.
   assign edge_w = stable_d ^ stable_q;

   function automatic logic [KW-1:0] rr_index(input logic [KW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_KEYS) s = s - NUM_KEYS;
      return KW'(s);
   endfunction

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (!grant_valid && !fifo_full && pending_q[rr_index(rr_ptr_q, k)]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_index(rr_ptr_q, k);
         end
      end
   end

   always_comb begin
      pending_d = pending_q;
      lost_d    = lost_q;
      rr_ptr_d  = rr_ptr_q;
      if (ctrl_wr && writedata[CTRL_CLR_LOST_BIT]) lost_d = 1'b0;
      if (grant_valid) begin
         pending_d[grant_idx] = 1'b0;
         rr_ptr_d = (grant_idx == KW'(NUM_KEYS - 1)) ? '0 : grant_idx + KW'(1);
      end
      // A key granted this cycle has already shipped its old event, so no loss.
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (edge_w[i]) begin
            if (pending_q[i] && !(grant_valid && grant_idx == KW'(i))) lost_d = 1'b1;
            pending_d[i] = 1'b1;
         end
      end
   end

   assign fifo_wdata = {stable_q[grant_idx], 5'(grant_idx)};
   assign fifo_pop   = read && (address == ADDR_EVENT);

   keypress_event_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (grant_valid),
      .data_i  (fifo_wdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      readdata_d = '0;
      irq_en_d   = irq_en_q;
      if (ctrl_wr) irq_en_d = writedata[CTRL_IRQ_EN_BIT];
      case (address)
         ADDR_STATE: readdata_d[NUM_KEYS-1:0] = stable_q;
         ADDR_EVENT: readdata_d = fifo_empty ? 32'd0 : event_word(fifo_rdata);
         ADDR_STATUS: begin
            readdata_d[STAT_COUNT_MSB:STAT_COUNT_LSB] = 7'(fifo_count);
            readdata_d[STAT_EMPTY_BIT] = fifo_empty;
            readdata_d[STAT_FULL_BIT]  = fifo_full;
            readdata_d[STAT_LOST_BIT]  = lost_q;
            readdata_d[STAT_PEND_BIT]  = |pending_q;
         end
         default: readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         lost_q     <= 1'b0;
         rr_ptr_q   <= '0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         pending_q <= pending_d;
         lost_q    <= lost_d;
         rr_ptr_q  <= rr_ptr_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_en_q & ~fifo_empty;
         if (read) readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
